z16_fetch: RTL and testbench
============================

Z16_FETCH -- requirements
Module: z16_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC loaded on reset; bit 0 is ignored (forced 0).
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 o_imem_addr  output  16  SHALL be the byte address presented to the combinational instruction memory.
REQ-005 i_imem_instr  input  16  SHALL be the instruction word returned by that memory in the same cycle.
REQ-006 i_redirect  input  1  SHALL request a branch/jump redirect.
REQ-007 i_redirect_pc  input  16  SHALL be the redirect target byte address; bit 0 is ignored.
REQ-008 i_halt  input  1  SHALL request that fetching stop (level-sensitive).
REQ-009 i_ready  input  1  SHALL indicate that decode accepts the head entry this cycle.
REQ-010 o_valid  output  1  SHALL indicate that o_instr/o_pc hold a valid fetched entry.
REQ-011 o_instr  output  16  SHALL be the head-entry instruction.
REQ-012 o_pc  output  16  SHALL be the head-entry byte address.
REQ-013 o_halted  output  1  SHALL be high while the FSM is in HALT.

Function
REQ-014 Block SHALL hold a PC register and a 2-entry FIFO of {pc, instr}; o_imem_addr SHALL equal the PC register combinationally.
REQ-015 FSM SHALL have two states: RUN and HALT; reset state RUN.
REQ-016 RUN: push {PC, i_imem_instr} and set PC <= PC+2 when (count<2) or (count==2 and pop this cycle); otherwise hold PC, no push.
REQ-017 Pop SHALL occur when o_valid && i_ready; push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-018 o_valid SHALL be (count != 0); o_instr/o_pc SHALL show the head entry, and SHALL be 16'h0000 when count==0.
REQ-019 Fetch latency SHALL be one cycle: a word pushed at edge N is visible on o_instr after edge N when the FIFO was empty.
REQ-020 PC arithmetic SHALL be modulo 2^16: 16'hFFFE + 2 wraps to 16'h0000 with no flag.
REQ-021 i_redirect SHALL take priority over all other events: at that edge, flush FIFO (count<=0), discard any pop/push, PC <= {i_redirect_pc[15:1],1'b0}.
REQ-022 Cycle after redirect: o_valid=0; fetch from the target resumes normally (one bubble).
REQ-023 i_halt high in RUN, without redirect, SHALL move FSM to HALT at that edge with no push that cycle; PC holds.
REQ-024 HALT: no push, PC holds, pops continue so the FIFO drains; o_halted=1.
REQ-025 HALT -> RUN SHALL occur on the first edge with i_halt low or i_redirect high; redirect applies per REQ-021 in the same edge.
REQ-026 Pops with count==0 SHALL be impossible (o_valid gates pop); i_ready when empty SHALL have no effect.

Reset
REQ-027 While i_rst_n==0: PC=RESET_PC with bit 0 cleared, count=0, FSM=RUN, o_valid=0, o_instr=0, o_pc=0, o_halted=0, o_imem_addr=RESET_PC.
REQ-028 Assertion mid-operation SHALL immediately discard all FIFO contents and in-flight redirect/halt; first push occurs on the first rising edge after deassertion.

Verification
REQ-029 Reset, memory word0=16'h004B, word1=16'h405A, i_ready=1 -> after edge 1: o_valid=1, o_pc=0000, o_instr=004B; after edge 2: o_pc=0002, o_instr=405A.
REQ-030 i_ready=0 from reset -> after 2 edges count=2, o_imem_addr=0004, PC holds thereafter; head stays 0000/004B; raise i_ready -> entries drain in order 0000, 0002, 0004.
REQ-031 Redirect to 16'h0011 with count==2 and i_ready=1 -> next cycle o_valid=0, o_imem_addr=0010; following cycle o_pc=0010.
REQ-032 PC=FFFE, i_ready=1 -> pushes FFFE then 0000; o_pc sequence FFFE, 0000.
REQ-033 i_halt=1 with count==1 -> o_halted=1 next cycle, one remaining entry pops, o_valid=0, o_imem_addr frozen; redirect while halted -> RUN, fetch from target.
REQ-034 i_rst_n low asynchronously mid-stream (between edges) -> o_valid=0, o_imem_addr=RESET_PC immediately, without a clock edge.

Source files
------------

// File: rtl/z16_fetch.sv
// z16_fetch: instruction fetch stage with a PC register, a RUN/HALT FSM and a
// two-entry {pc, instr} queue feeding decode. The instruction memory is
// combinational: o_imem_addr is the PC and i_imem_instr answers in the same cycle.
//
// Handshake: o_valid is high whenever the queue holds an entry. o_pc/o_instr
// show the head entry. The head is consumed on any rising edge where
// o_valid && i_ready. A redirect at that edge overrides the pop and flushes
// the queue.
module z16_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_instr,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_halt,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_halted
);

  localparam logic [0:0]  S_RUN   = 1'b0;
  localparam logic [0:0]  S_HALT  = 1'b1;
  // Instructions are halfword aligned, so bit 0 of any PC is always zero.
  localparam logic [15:0] PC_INIT = {RESET_PC[15:1], 1'b0};

  logic [0:0]  state;
  logic [15:0] pc;
  logic [1:0]  cnt;
  logic [15:0] head_pc, head_instr;
  logic [15:0] tail_pc, tail_instr;
  logic        pop;
  logic        push;

  assign pop  = o_valid && i_ready;
  // A full queue may still accept a new word when the head leaves this cycle.
  assign push = (state == S_RUN) && !i_halt && ((cnt != 2'd2) || pop);

  // Control FSM and PC. A redirect wins over halt, resume and fetch advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_RUN;
      pc    <= PC_INIT;
    end else if (i_redirect) begin
      state <= S_RUN;
      pc    <= {i_redirect_pc[15:1], 1'b0};
    end else begin
      case (state)
        S_RUN: begin
          if (i_halt) begin
            state <= S_HALT;
          end else if (push) begin
            pc <= pc + 16'd2;
          end
        end
        default: begin
          if (!i_halt) begin
            state <= S_RUN;
          end
        end
      endcase
    end
  end

  // Two-entry queue. The head is always entry 0; a simultaneous push and pop
  // shifts the tail forward and appends behind it so order is preserved.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= 2'd0;
      head_pc    <= 16'h0000;
      head_instr <= 16'h0000;
      tail_pc    <= 16'h0000;
      tail_instr <= 16'h0000;
    end else if (i_redirect) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            head_pc    <= pc;
            head_instr <= i_imem_instr;
          end else begin
            tail_pc    <= pc;
            tail_instr <= i_imem_instr;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head_pc    <= tail_pc;
          head_instr <= tail_instr;
          cnt        <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head_pc    <= pc;
            head_instr <= i_imem_instr;
          end else begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            tail_pc    <= pc;
            tail_instr <= i_imem_instr;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_imem_addr = pc;
  assign o_valid     = (cnt != 2'd0);
  assign o_pc        = o_valid ? head_pc    : 16'h0000;
  assign o_instr     = o_valid ? head_instr : 16'h0000;
  // o_halted is the FSM state itself and doubles as its debug view.
  assign o_halted    = (state == S_HALT);

endmodule

// File: tb/tb_z16_fetch.sv
// tb_z16_fetch: directed scenarios followed by randomized traffic, checked
// against a queue-based reference model of the fetch stage.
`timescale 1ns/1ps
module tb_z16_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        ready;
  logic        valid;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        halted;

  logic [15:0] mem [256];
  logic [31:0] exp_q [$];
  logic [15:0] mpc;
  logic        mhalt;
  int          checks = 0;
  int          errors = 0;

  z16_fetch #(.RESET_PC(RST_PC)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_addr   (imem_addr),
    .i_imem_instr  (imem_instr),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_halt        (halt),
    .i_ready       (ready),
    .o_valid       (valid),
    .o_instr       (instr),
    .o_pc          (pc),
    .o_halted      (halted)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory, 256 halfwords mirrored over the space.
  assign imem_instr = mem[imem_addr[8:1]];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic h, input logic rd, input logic [15:0] rpc);
    ready       = r;
    halt        = h;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  // Reference model: exp_q is the queue of fetched-but-unaccepted entries.
  // Each edge fetches one word at the model PC if there is room, unless halted
  // or redirected. The monitor removes accepted entries.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      mpc   <= RST_PC & 16'hFFFE;
      mhalt <= 1'b0;
    end else if (redirect) begin
      exp_q.delete();
      mpc   <= redirect_pc & 16'hFFFE;
      mhalt <= 1'b0;
    end else if (mhalt) begin
      if (!halt) mhalt <= 1'b0;
    end else if (halt) begin
      mhalt <= 1'b1;
    end else if (exp_q.size() < 2) begin
      exp_q.push_back({mpc, mem[mpc[8:1]]});
      mpc <= mpc + 16'd2;
    end
  end

  // Monitor: mid-cycle, compare outputs with the model and retire the head
  // entry when decode accepts it.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mon_valid", {15'd0, valid}, {15'd0, exp_q.size() != 0});
      chk("mon_imem_addr", imem_addr, mpc);
      chk("mon_halted", {15'd0, halted}, {15'd0, mhalt});
      if (exp_q.size() != 0) begin
        chk("mon_head_pc", pc, exp_q[0][31:16]);
        chk("mon_head_instr", instr, exp_q[0][15:0]);
        if (ready) void'(exp_q.pop_front());
      end else begin
        chk("mon_empty_pc", pc, 16'h0000);
        chk("mon_empty_instr", instr, 16'h0000);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h004B;
    mem[1] = 16'h405A;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);

    // Values held during reset.
    #3;
    chk("rst_valid", {15'd0, valid}, 16'd0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_imem_addr", imem_addr, RST_PC);

    // First two fetches with decode always ready.
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("e1_valid", {15'd0, valid}, 16'd1);
    chk("e1_pc", pc, 16'h0000);
    chk("e1_instr", instr, 16'h004B);
    tick();
    chk("e2_pc", pc, 16'h0002);
    chk("e2_instr", instr, 16'h405A);

    // Backpressure from reset: queue fills, PC stalls, then drains in order.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("bp_addr_full", imem_addr, 16'h0004);
    tick();
    chk("bp_addr_hold", imem_addr, 16'h0004);
    chk("bp_head_pc", pc, 16'h0000);
    chk("bp_head_instr", instr, 16'h004B);
    ready = 1'b1;
    tick();
    chk("bp_drain1", pc, 16'h0002);
    tick();
    chk("bp_drain2", pc, 16'h0004);

    // Redirect to an odd address while the queue is full.
    ready = 1'b0;
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b1, 16'h0011);
    tick();
    chk("rd_valid", {15'd0, valid}, 16'd0);
    chk("rd_addr", imem_addr, 16'h0010);
    redirect = 1'b0;
    tick();
    chk("rd_pc", pc, 16'h0010);

    // PC wrap from FFFE to 0000.
    drive(1'b1, 1'b0, 1'b1, 16'hFFFE);
    tick();
    chk("wrap_addr", imem_addr, 16'hFFFE);
    redirect = 1'b0;
    tick();
    chk("wrap_pc0", pc, 16'hFFFE);
    tick();
    chk("wrap_pc1", pc, 16'h0000);

    // Halt with one entry queued, drain, then redirect out of halt.
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    tick();
    chk("h_halted", {15'd0, halted}, 16'd1);
    chk("h_valid", {15'd0, valid}, 16'd1);
    chk("h_addr", imem_addr, 16'h0002);
    ready = 1'b1;
    tick();
    chk("h_drained", {15'd0, valid}, 16'd0);
    tick();
    chk("h_addr_frozen", imem_addr, 16'h0002);
    chk("h_still_halted", {15'd0, halted}, 16'd1);
    drive(1'b1, 1'b1, 1'b1, 16'h0040);
    tick();
    chk("h_resume_halted", {15'd0, halted}, 16'd0);
    chk("h_resume_addr", imem_addr, 16'h0040);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("h_resume_pc", pc, 16'h0040);

    // Asynchronous reset between edges takes effect without a clock edge.
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {15'd0, valid}, 16'd0);
    chk("arst_addr", imem_addr, RST_PC);
    tick();
    rst_n = 1'b1;

    // Randomized traffic, occasionally hitting the wrap point and reset.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0, tgt);
      tick();
    end

    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int n = 0; n < 5; n++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
